// File: rtl/commit_goal_monitor.sv
// commit_goal_monitor
// Run-control and statistics block that sits beside the commit stage. It counts
// RUN cycles, committed micro-ops and committed RISC-V ops. It ends a run on a
// programmable goal PC, on a cycle budget, or on a commit stall.
// Optional feature macro: RSD_COMMIT_MONITOR_STALL_DETECT_EN enables the
// no-commit deadlock detector (doneReason 3). Without it, STALL_LIMIT is unused.
module commit_goal_monitor #(
  parameter int COMMIT_WIDTH = 2,
  parameter int PC_WIDTH     = 32,
  parameter int GOAL_NUM     = 2,
  parameter int CNT_WIDTH    = 48,
  parameter int STALL_LIMIT  = 4096
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [COMMIT_WIDTH-1:0]          commit,
  input  logic [COMMIT_WIDTH*PC_WIDTH-1:0] commitPC,
  input  logic [COMMIT_WIDTH-1:0]          commitFirstMop,
  input  logic [GOAL_NUM*PC_WIDTH-1:0]     goalPC,
  input  logic [GOAL_NUM-1:0]              goalEnable,
  input  logic [CNT_WIDTH-1:0]             maxCycles,
  output logic                             running,
  output logic                             done,
  output logic [1:0]                       doneReason,
  output logic [$clog2(GOAL_NUM):0]        goalIndex,
  output logic [$clog2(COMMIT_WIDTH):0]    goalLane,
  output logic [CNT_WIDTH-1:0]             cycleCount,
  output logic [CNT_WIDTH-1:0]             numMicroOp,
  output logic [CNT_WIDTH-1:0]             numRiscvOp
);

  localparam int IdxWidth  = $clog2(GOAL_NUM) + 1;
  localparam int LaneWidth = $clog2(COMMIT_WIDTH) + 1;
  localparam int IncWidth  = $clog2(COMMIT_WIDTH + 1);

  localparam logic [1:0] ReasonNone     = 2'd0;
  localparam logic [1:0] ReasonGoal     = 2'd1;
  localparam logic [1:0] ReasonTimeout  = 2'd2;
  localparam logic [1:0] ReasonDeadlock = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT state;
  stateT nextState;

  logic                 startAccept;
  logic [IncWidth-1:0]  microInc;
  logic [IncWidth-1:0]  riscvInc;
  logic [CNT_WIDTH-1:0] cycleNext;
  logic [CNT_WIDTH-1:0] microNext;
  logic [CNT_WIDTH-1:0] riscvNext;
  logic                 goalHit;
  logic [IdxWidth-1:0]  hitIndex;
  logic [LaneWidth-1:0] hitLane;
  logic                 timeoutHit;
  logic                 deadlockHit;

  // Counters stick at all-ones instead of wrapping so long runs stay meaningful
  function automatic logic [CNT_WIDTH-1:0] satAdd(input logic [CNT_WIDTH-1:0] a,
                                                  input logic [IncWidth-1:0] b);
    logic [CNT_WIDTH:0] sum;
    sum = {1'b0, a} + (CNT_WIDTH + 1)'(b);
    return sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
  endfunction

  // A start pulse only matters when no run is in progress
  assign startAccept = start && (state != RUN);

  // Population counts of committed micro-ops and of first micro-ops; lanes may be sparse
  always_comb begin
    microInc = '0;
    riscvInc = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      microInc = microInc + IncWidth'(commit[i]);
      riscvInc = riscvInc + IncWidth'(commit[i] & commitFirstMop[i]);
    end
  end

  // Counter values for this cycle if it is a RUN cycle
  always_comb begin
    cycleNext = satAdd(cycleCount, IncWidth'(1));
    microNext = satAdd(numMicroOp, microInc);
    riscvNext = satAdd(numRiscvOp, riscvInc);
  end

  // Goal match: scanned from the top down so the last write is the lowest lane,
  // and within that lane the lowest comparator
  always_comb begin
    goalHit  = 1'b0;
    hitIndex = '0;
    hitLane  = '0;
    for (int lane = COMMIT_WIDTH - 1; lane >= 0; lane--) begin
      for (int g = GOAL_NUM - 1; g >= 0; g--) begin
        if (commit[lane] && goalEnable[g] &&
            (commitPC[lane*PC_WIDTH +: PC_WIDTH] == goalPC[g*PC_WIDTH +: PC_WIDTH])) begin
          goalHit  = 1'b1;
          hitIndex = IdxWidth'(g);
          hitLane  = LaneWidth'(lane);
        end
      end
    end
  end

  // Cycle budget compares against the count that includes the current cycle
  assign timeoutHit = (maxCycles != '0) && (cycleNext >= maxCycles);

`ifdef RSD_COMMIT_MONITOR_STALL_DETECT_EN
  localparam int StallWidth = $clog2(STALL_LIMIT + 1);

  logic [StallWidth-1:0] stallCount;
  logic [StallWidth-1:0] stallNext;

  // Consecutive no-commit cycles; any commit restarts the count
  always_comb begin
    stallNext   = (commit != '0) ? '0 : stallCount + StallWidth'(1);
    deadlockHit = (stallNext >= StallWidth'(STALL_LIMIT));
  end

  // Stall counter only advances while a run is active and restarts with each run
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCount <= '0;
    end else if (startAccept) begin
      stallCount <= '0;
    end else if (state == RUN) begin
      stallCount <= stallNext;
    end
  end
`else
  assign deadlockHit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state decision; any finishing event ends the run
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = RUN;
      RUN:     if (goalHit || timeoutHit || deadlockHit) nextState = DONE;
      DONE:    if (start) nextState = RUN;
      default: nextState = IDLE;
    endcase
  end

  // Status flags decoded straight from the state register
  always_comb begin
    running = (state == RUN);
    done    = (state == DONE);
  end

  // Statistics and finish cause; a new run clears everything, RUN accumulates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycleCount <= '0;
      numMicroOp <= '0;
      numRiscvOp <= '0;
      doneReason <= ReasonNone;
      goalIndex  <= '0;
      goalLane   <= '0;
    end else if (startAccept) begin
      cycleCount <= '0;
      numMicroOp <= '0;
      numRiscvOp <= '0;
      doneReason <= ReasonNone;
      goalIndex  <= '0;
      goalLane   <= '0;
    end else if (state == RUN) begin
      cycleCount <= cycleNext;
      numMicroOp <= microNext;
      numRiscvOp <= riscvNext;
      if (goalHit) begin
        doneReason <= ReasonGoal;
        goalIndex  <= hitIndex;
        goalLane   <= hitLane;
      end else if (timeoutHit) begin
        doneReason <= ReasonTimeout;
      end else if (deadlockHit) begin
        doneReason <= ReasonDeadlock;
      end
    end
  end

endmodule

// File: tb/tb_commit_goal_monitor.sv
// Directed testbench for commit_goal_monitor. A second instance with 4-bit
// counters exercises saturation. Deadlock checks follow the
// RSD_COMMIT_MONITOR_STALL_DETECT_EN build option.
module tb_commit_goal_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  commit;
  logic [63:0] commitPC;
  logic [1:0]  commitFirstMop;
  logic [63:0] goalPC;
  logic [1:0]  goalEnable;
  logic [47:0] maxCycles;
  logic        running;
  logic        done;
  logic [1:0]  doneReason;
  logic [1:0]  goalIndex;
  logic [1:0]  goalLane;
  logic [47:0] cycleCount;
  logic [47:0] numMicroOp;
  logic [47:0] numRiscvOp;

  logic        startSat;
  logic [1:0]  commitSat;
  logic [63:0] commitPCSat;
  logic [1:0]  firstSat;
  logic [63:0] goalPCSat;
  logic [1:0]  goalEnableSat;
  logic [3:0]  maxCyclesSat;
  logic        runningSat;
  logic        doneSat;
  logic [1:0]  reasonSat;
  logic [1:0]  goalIndexSat;
  logic [1:0]  goalLaneSat;
  logic [3:0]  cycleSat;
  logic [3:0]  microSat;
  logic [3:0]  riscvSat;

  int assertCount = 0;
  int failCount   = 0;

  commit_goal_monitor #(
    .COMMIT_WIDTH(2), .PC_WIDTH(32), .GOAL_NUM(2), .CNT_WIDTH(48), .STALL_LIMIT(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .commit(commit), .commitPC(commitPC),
    .commitFirstMop(commitFirstMop), .goalPC(goalPC), .goalEnable(goalEnable),
    .maxCycles(maxCycles), .running(running), .done(done), .doneReason(doneReason),
    .goalIndex(goalIndex), .goalLane(goalLane), .cycleCount(cycleCount),
    .numMicroOp(numMicroOp), .numRiscvOp(numRiscvOp)
  );

  commit_goal_monitor #(
    .COMMIT_WIDTH(2), .PC_WIDTH(32), .GOAL_NUM(2), .CNT_WIDTH(4)
  ) dutSat (
    .clk(clk), .rst(rst), .start(startSat), .commit(commitSat), .commitPC(commitPCSat),
    .commitFirstMop(firstSat), .goalPC(goalPCSat), .goalEnable(goalEnableSat),
    .maxCycles(maxCyclesSat), .running(runningSat), .done(doneSat), .doneReason(reasonSat),
    .goalIndex(goalIndexSat), .goalLane(goalLaneSat), .cycleCount(cycleSat),
    .numMicroOp(microSat), .numRiscvOp(riscvSat)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive the commit lanes and hold them for the given number of edges
  task automatic applyStimulus(input logic [1:0] c, input logic [1:0] first,
                               input logic [31:0] pc0, input logic [31:0] pc1,
                               input int cycles);
    commit         = c;
    commitFirstMop = first;
    commitPC       = {pc1, pc0};
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; commit = '0; commitPC = '0; commitFirstMop = '0;
    goalPC = '0; goalEnable = '0; maxCycles = '0;
    startSat = 1'b0; commitSat = '0; commitPCSat = '0; firstSat = '0;
    goalPCSat = '0; goalEnableSat = '0; maxCyclesSat = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_running", 64'(running), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_reason", 64'(doneReason), 64'd0);
    checkOutput("rst_cycles", 64'(cycleCount), 64'd0);
    checkOutput("rst_micro", 64'(numMicroOp), 64'd0);
    rst = 1'b0;

    // Reset mid-run
    pulseStart();
    checkOutput("start_running", 64'(running), 64'd1);
    checkOutput("start_cycles", 64'(cycleCount), 64'd0);
    applyStimulus(2'b11, 2'b11, 32'h100, 32'h104, 5);
    checkOutput("pre_rst_cycles", 64'(cycleCount), 64'd5);
    checkOutput("pre_rst_micro", 64'(numMicroOp), 64'd10);
    rst = 1'b1;
    #1;
    checkOutput("midrst_running", 64'(running), 64'd0);
    checkOutput("midrst_cycles", 64'(cycleCount), 64'd0);
    checkOutput("midrst_micro", 64'(numMicroOp), 64'd0);
    checkOutput("midrst_riscv", 64'(numRiscvOp), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("midrst_done", 64'(done), 64'd0);

    // Op counting with mixed first-micro-op flags and a sparse lane pattern
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 0);
    pulseStart();
    checkOutput("restart_cycles", 64'(cycleCount), 64'd0);
    checkOutput("restart_micro", 64'(numMicroOp), 64'd0);
    applyStimulus(2'b11, 2'b01, 32'h100, 32'h104, 10);
    applyStimulus(2'b10, 2'b10, 32'h100, 32'h104, 3);
    checkOutput("ops_cycles", 64'(cycleCount), 64'd13);
    checkOutput("ops_micro", 64'(numMicroOp), 64'd23);
    checkOutput("ops_riscv", 64'(numRiscvOp), 64'd13);

    // Two lanes hit different goals in one cycle: lane 0 wins
    goalPC     = {32'h8000_0200, 32'h8000_1000};
    goalEnable = 2'b11;
    applyStimulus(2'b11, 2'b11, 32'h8000_0200, 32'h8000_1000, 1);
    checkOutput("goal_done", 64'(done), 64'd1);
    checkOutput("goal_running", 64'(running), 64'd0);
    checkOutput("goal_reason", 64'(doneReason), 64'd1);
    checkOutput("goal_lane", 64'(goalLane), 64'd0);
    checkOutput("goal_index", 64'(goalIndex), 64'd1);
    checkOutput("goal_micro", 64'(numMicroOp), 64'd25);
    checkOutput("goal_riscv", 64'(numRiscvOp), 64'd15);
    checkOutput("goal_cycles", 64'(cycleCount), 64'd14);

    // Counters hold in DONE
    applyStimulus(2'b11, 2'b11, 32'h100, 32'h104, 2);
    checkOutput("hold_micro", 64'(numMicroOp), 64'd25);
    checkOutput("hold_cycles", 64'(cycleCount), 64'd14);

    // Disabled comparator is ignored; hit lands on lane 1
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 0);
    pulseStart();
    checkOutput("rerun_reason", 64'(doneReason), 64'd0);
    goalEnable = 2'b01;
    applyStimulus(2'b11, 2'b01, 32'h8000_0200, 32'h8000_1000, 1);
    checkOutput("lane1_reason", 64'(doneReason), 64'd1);
    checkOutput("lane1_lane", 64'(goalLane), 64'd1);
    checkOutput("lane1_index", 64'(goalIndex), 64'd0);
    checkOutput("lane1_micro", 64'(numMicroOp), 64'd2);
    checkOutput("lane1_riscv", 64'(numRiscvOp), 64'd1);

    // Start and goal together in DONE: start wins, goal ignored
    goalEnable = 2'b11;
    applyStimulus(2'b11, 2'b11, 32'h8000_1000, 32'h8000_0200, 0);
    pulseStart();
    checkOutput("startwin_running", 64'(running), 64'd1);
    checkOutput("startwin_micro", 64'(numMicroOp), 64'd0);
    checkOutput("startwin_reason", 64'(doneReason), 64'd0);

    // Goal on the budget cycle outranks timeout
    maxCycles = 48'd100;
    applyStimulus(2'b01, 2'b01, 32'h100, 32'h104, 99);
    checkOutput("tg_running99", 64'(running), 64'd1);
    checkOutput("tg_cycles99", 64'(cycleCount), 64'd99);
    applyStimulus(2'b01, 2'b01, 32'h8000_1000, 32'h104, 1);
    checkOutput("tg_done", 64'(done), 64'd1);
    checkOutput("tg_reason", 64'(doneReason), 64'd1);
    checkOutput("tg_cycles", 64'(cycleCount), 64'd100);

    // Timeout alone
    applyStimulus(2'b01, 2'b01, 32'h100, 32'h104, 0);
    pulseStart();
    applyStimulus(2'b01, 2'b01, 32'h100, 32'h104, 99);
    checkOutput("to_running99", 64'(running), 64'd1);
    applyStimulus(2'b01, 2'b01, 32'h100, 32'h104, 1);
    checkOutput("to_done", 64'(done), 64'd1);
    checkOutput("to_reason", 64'(doneReason), 64'd2);
    checkOutput("to_cycles", 64'(cycleCount), 64'd100);
    checkOutput("to_micro", 64'(numMicroOp), 64'd100);

    // Idle run with timeout and goals disabled
    maxCycles  = '0;
    goalEnable = 2'b00;
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 0);
    pulseStart();
`ifdef RSD_COMMIT_MONITOR_STALL_DETECT_EN
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 6);
    applyStimulus(2'b01, 2'b01, 32'h100, 32'h0, 1);
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 7);
    checkOutput("stall_running14", 64'(running), 64'd1);
    checkOutput("stall_cycles14", 64'(cycleCount), 64'd14);
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 1);
    checkOutput("stall_done", 64'(done), 64'd1);
    checkOutput("stall_reason", 64'(doneReason), 64'd3);
    checkOutput("stall_cycles", 64'(cycleCount), 64'd15);
`else
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 1000);
    checkOutput("idle_running", 64'(running), 64'd1);
    checkOutput("idle_done", 64'(done), 64'd0);
    checkOutput("idle_reason", 64'(doneReason), 64'd0);
    checkOutput("idle_cycles", 64'(cycleCount), 64'd1000);
`endif

    // Saturation on the 4-bit instance
    startSat = 1'b1;
    @(posedge clk);
    #1;
    startSat  = 1'b0;
    commitSat = 2'b11;
    firstSat  = 2'b11;
    repeat (7) begin @(posedge clk); #1; end
    checkOutput("sat_micro7", 64'(microSat), 64'd14);
    checkOutput("sat_cycles7", 64'(cycleSat), 64'd7);
    @(posedge clk);
    #1;
    checkOutput("sat_micro8", 64'(microSat), 64'd15);
    checkOutput("sat_cycles8", 64'(cycleSat), 64'd8);
    repeat (12) begin @(posedge clk); #1; end
    checkOutput("sat_micro20", 64'(microSat), 64'd15);
    checkOutput("sat_riscv20", 64'(riscvSat), 64'd15);
    checkOutput("sat_cycles20", 64'(cycleSat), 64'd15);
    checkOutput("sat_running", 64'(runningSat), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
